// File: rtl/surf_tref_hold_ctrl.sv
// SURF per-LAB TREF generator and HOLD synchroniser/debouncer/counter front end.
// Define SURF_HOLD_COUNT_EN to build the per-LAB saturating HOLD event counters.
module surf_tref_hold_ctrl #(
  parameter int NUM_LABS     = 4,
  parameter int DIV_WIDTH    = 8,
  parameter int TREF_DIV_RST = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE     = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          clk33_i,
  input  logic                          reset_i,
  input  logic [DIV_WIDTH-1:0]          tref_div_i,
  input  logic                          tref_load_i,
  input  logic [NUM_LABS-1:0]           tref_en_i,
  output logic [NUM_LABS-1:0]           tref_o,
  input  logic [NUM_LABS-1:0]           hold_i,
  output logic [NUM_LABS-1:0]           hold_o,
  output logic [NUM_LABS-1:0]           hold_rise_o,
  input  logic                          cnt_clr_i,
  output logic [NUM_LABS*CNT_WIDTH-1:0] hold_cnt_o,
  input  logic                          cmd_i,
  output logic                          cmd_o
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(TREF_DIV_RST);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 tref_int_q, tref_int_d;
  logic [NUM_LABS-1:0]  en_q, en_d;
  logic [NUM_LABS-1:0]  tref_q;

  always_comb begin
    div_reg_d  = div_reg_q;
    div_cnt_d  = div_cnt_q + 1'b1;
    tref_int_d = tref_int_q;
    if (tref_load_i) begin
      div_reg_d  = (tref_div_i == '0) ? DIV_ONE : tref_div_i;
      div_cnt_d  = '0;
      tref_int_d = 1'b0;
    end else if (div_cnt_q >= div_reg_q - DIV_ONE) begin
      div_cnt_d  = '0;
      tref_int_d = ~tref_int_q;
    end
    // Enables only change on a TREF rising edge, so no runt pulses.
    en_d = (tref_int_d & ~tref_int_q) ? tref_en_i : en_q;
  end

  always_ff @(posedge clk33_i or posedge reset_i) begin
    if (reset_i) begin
      div_reg_q  <= DIV_RST;
      div_cnt_q  <= '0;
      tref_int_q <= 1'b0;
      en_q       <= '0;
      tref_q     <= '0;
    end else begin
      div_reg_q  <= div_reg_d;
      div_cnt_q  <= div_cnt_d;
      tref_int_q <= tref_int_d;
      en_q       <= en_d;
      tref_q     <= {NUM_LABS{tref_int_d}} & en_d;
    end
  end

  logic [NUM_LABS-1:0]    hsync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] csync_q;
  logic [NUM_LABS-1:0]    hold_s;
  logic [DBW-1:0]         db_q [NUM_LABS];
  logic [DBW-1:0]         db_d [NUM_LABS];
  logic [NUM_LABS-1:0]    hold_q, hold_d;
  logic [NUM_LABS-1:0]    hold_dly_q;
  logic [NUM_LABS-1:0]    rise_q;

  assign hold_s = hsync_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < NUM_LABS; i++) begin
      db_d[i]   = '0;
      hold_d[i] = hold_q[i];
      if (hold_s[i] != hold_q[i]) begin
        if (db_q[i] == DB_LAST) hold_d[i] = ~hold_q[i];
        else                    db_d[i]   = db_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk33_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) hsync_q[s] <= '0;
      for (int i = 0; i < NUM_LABS; i++) db_q[i] <= '0;
      csync_q    <= '0;
      hold_q     <= '0;
      hold_dly_q <= '0;
      rise_q     <= '0;
    end else begin
      hsync_q[0] <= hold_i;
      for (int s = 1; s < SYNC_STAGES; s++) hsync_q[s] <= hsync_q[s-1];
      for (int i = 0; i < NUM_LABS; i++) db_q[i] <= db_d[i];
      csync_q    <= {csync_q[SYNC_STAGES-2:0], cmd_i};
      hold_q     <= hold_d;
      hold_dly_q <= hold_q;
      rise_q     <= hold_q & ~hold_dly_q;
    end
  end

`ifdef SURF_HOLD_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_LABS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_LABS];

  // Clear wins, but a rise in the same cycle still counts.
  always_comb begin
    for (int i = 0; i < NUM_LABS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr_i)
        cnt_d[i] = CNT_WIDTH'(rise_q[i]);
      else if (rise_q[i] && !(&cnt_q[i]))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk33_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_LABS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LABS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_LABS; g++) begin : g_cnt
    assign hold_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign hold_cnt_o     = '0;
`endif

  assign tref_o      = tref_q;
  assign hold_o      = hold_q;
  assign hold_rise_o = rise_q;
  assign cmd_o       = csync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_surf_tref_hold_ctrl.sv
// Scoreboard bench for surf_tref_hold_ctrl: TREF gating, HOLD debounce,
// rise strobes, counters (with or without SURF_HOLD_COUNT_EN) and reset.
module tb_surf_tref_hold_ctrl;

  localparam int N  = 4;
  localparam int CW = 4;
`ifdef SURF_HOLD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_i;
  logic [7:0]      tref_div_i;
  logic            tref_load_i;
  logic [N-1:0]    tref_en_i;
  logic [N-1:0]    tref_o;
  logic [N-1:0]    hold_i;
  logic [N-1:0]    hold_o;
  logic [N-1:0]    hold_rise_o;
  logic            cnt_clr_i;
  logic [N*CW-1:0] hold_cnt_o;
  logic            cmd_i;
  logic            cmd_o;

  always #5 clk = ~clk;

  surf_tref_hold_ctrl #(
    .NUM_LABS(N), .DIV_WIDTH(8), .TREF_DIV_RST(1),
    .SYNC_STAGES(2), .DEBOUNCE(3), .CNT_WIDTH(CW)
  ) dut (
    .clk33_i(clk), .reset_i(reset_i),
    .tref_div_i(tref_div_i), .tref_load_i(tref_load_i),
    .tref_en_i(tref_en_i), .tref_o(tref_o),
    .hold_i(hold_i), .hold_o(hold_o), .hold_rise_o(hold_rise_o),
    .cnt_clr_i(cnt_clr_i), .hold_cnt_o(hold_cnt_o),
    .cmd_i(cmd_i), .cmd_o(cmd_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt(input int lab);
    return hold_cnt_o[lab*CW +: CW];
  endfunction

  function automatic bit hi5(input int i);
    return (i >= 5) && (((i - 5) % 10) < 5);
  endfunction

  function automatic logic [3:0] en3(input int i);
    return (i >= 7 && i < 22) ? 4'b0100 : 4'b0101;
  endfunction

  logic [31:0] ev;
  bit          seen;

  initial begin
    reset_i = 1'b1; tref_div_i = '0; tref_load_i = 1'b0;
    tref_en_i = 4'hF; hold_i = '0; cnt_clr_i = 1'b0; cmd_i = 1'b0;
    step(); step();
    check("rst_tref", tref_o, 0);
    check("rst_hold", hold_o, 0);
    check("rst_rise", hold_rise_o, 0);
    check("rst_cnt", hold_cnt_o, 0);
    check("rst_cmd", cmd_o, 0);

    // div=1 after reset: toggle every cycle
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) push("t1_tref", (i % 2 == 0) ? 4'hF : 4'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      pop_chk(tref_o);
    end

    // div=5, en 0101: 5 high / 5 low
    for (int i = 0; i < 25; i++) push("t2_div5", hi5(i) ? 4'h5 : 4'h0);
    tref_div_i = 8'd5;
    tref_en_i  = 4'b0101;
    for (int i = 0; i < 25; i++) begin
      tref_load_i = (i == 0);
      step();
      pop_chk(tref_o);
    end

    // div=0 treated as 1
    for (int i = 0; i < 8; i++) push("t2_div0", (i % 2 == 1) ? 4'h5 : 4'h0);
    tref_div_i = 8'd0;
    for (int i = 0; i < 8; i++) begin
      tref_load_i = (i == 0);
      step();
      pop_chk(tref_o);
    end

    // drop en[0] mid-high, re-enable mid-low
    for (int i = 0; i < 35; i++) begin
      ev = hi5(i) ? {28'd0, en3(i - ((i - 5) % 10))} : 32'd0;
      push("t3_gate", ev);
    end
    tref_div_i = 8'd5;
    for (int i = 0; i < 35; i++) begin
      tref_en_i   = en3(i);
      tref_load_i = (i == 0);
      step();
      pop_chk(tref_o);
    end
    tref_load_i = 1'b0;
    tref_en_i   = '0;

    // 2-cycle HOLD glitch rejected
    for (int i = 0; i < 12; i++) begin
      push("t4s_hold", 0);
      push("t4s_rise", 0);
    end
    for (int i = 0; i < 12; i++) begin
      hold_i = (i < 2) ? 4'b0010 : 4'b0000;
      step();
      pop_chk(hold_o[1]);
      pop_chk(hold_rise_o[1]);
    end
    check("t4s_cnt", cnt(1), 0);

    // 8-cycle HOLD pulse accepted after 5 cycles; CMD path
    for (int i = 0; i < 20; i++) begin
      push("t4l_hold", (i >= 4 && i < 12) ? 1 : 0);
      push("t4l_rise", (i == 5) ? 1 : 0);
      push("t4l_cmd", (i >= 1 && i < 9) ? 1 : 0);
    end
    for (int i = 0; i < 20; i++) begin
      hold_i = (i < 8) ? 4'b0010 : 4'b0000;
      cmd_i  = (i < 8);
      step();
      pop_chk(hold_o[1]);
      pop_chk(hold_rise_o[1]);
      pop_chk(cmd_o);
    end
    check("t4l_cnt", cnt(1), CNT_EN ? 1 : 0);

    // clear, then 17 pulses saturate a 4-bit counter
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    check("t5_clr0", cnt(0), 0);
    check("t5_clr1", cnt(1), 0);
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < 10; i++) begin
        hold_i = (i < 4) ? 4'b0001 : 4'b0000;
        step();
      end
    end
    repeat (6) step();
    check("t5_sat", cnt(0), CNT_EN ? 15 : 0);

    // clear coinciding with a rise leaves 1
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      hold_i = (i < 4) ? 4'b0001 : 4'b0000;
      step();
      cnt_clr_i = hold_rise_o[0];
      if (hold_rise_o[0]) seen = 1'b1;
    end
    cnt_clr_i = 1'b0;
    step();
    check("t5_rise_seen", seen, 1);
    check("t5_clr_rise", cnt(0), CNT_EN ? 1 : 0);
    check("t5_clr_lab1", cnt(1), 0);

    // reset mid-TREF-high and mid-debounce
    tref_en_i  = 4'hF;
    tref_div_i = 8'd5;
    for (int i = 0; i < 8; i++) begin
      tref_load_i = (i == 0);
      hold_i      = (i < 5) ? 4'hF : 4'h0;
      step();
    end
    tref_load_i = 1'b0;
    check("t6_pre_tref", tref_o, 4'hF);
    check("t6_pre_hold", hold_o, 4'hF);
    #2;
    reset_i = 1'b1;
    #1;
    check("t6_rst_tref", tref_o, 0);
    check("t6_rst_hold", hold_o, 0);
    check("t6_rst_rise", hold_rise_o, 0);
    check("t6_rst_cnt", hold_cnt_o, 0);
    check("t6_rst_cmd", cmd_o, 0);
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) push("t6_tref", (i % 2 == 0) ? 4'hF : 4'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      pop_chk(tref_o);
    end
    check("t6_hold_after", hold_o, 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
